tone_sequencer: RTL and testbench
=================================

// Module: tone_sequencer
// PURPOSE
//  Sample source feeding the PDM modulator. Plays a fixed melody from an internal note ROM.
//  Each note comes from a DDS phase accumulator: sawtooth or square, 13-bit unsigned.
//  Advances only on the shared 4.8 MHz sample-enable strobe (24 MHz clk / 5), so the
//  modulator consumes exactly one new sample per enable.
// PARAMETERS
//  SAMPLE_W   13      output sample width; must equal modulator input width
//  PHASE_W    24      phase accumulator width; sample = phase[PHASE_W-1 -: SAMPLE_W]
//  NOTE_CNT   8       melody length (ROM entries, index 0..NOTE_CNT-1)
//  UNIT_TICKS 48000   sample enables per duration unit (10 ms at 4.8 MHz)
//  GAP_TICKS  4800    silent enables between notes (1 ms)
// PORTS
//  clk          in   1         24 MHz PLL clock
//  rst          in   1         asynchronous, active-high reset
//  sample_ce    in   1         one-clk strobe, 1 in 5 clks; sole advance condition
//  start        in   1         one-clk pulse: begin melody at note 0
//  stop         in   1         one-clk pulse: abort, return to idle
//  loop_en      in   1         1 = restart at note 0 after last note; sampled at end of last gap
//  wave_sel     in   1         0 = sawtooth, 1 = square (MSB of phase, full-scale 0 / 2^SAMPLE_W-1)
//  sample       out  SAMPLE_W  unsigned audio sample to modulator
//  sample_valid out  1         one-clk pulse, clk after each sample_ce (in any state)
//  busy         out  1         1 in PLAY or GAP
//  note_idx     out  3         index of current note ($clog2(NOTE_CNT))
// BEHAVIOUR
//  Reset (async): state=IDLE, phase=0, counters=0, sample=2^(SAMPLE_W-1) (midscale 4096),
//   sample_valid=0, busy=0, note_idx=0.
//  Latency: on clk where sample_ce=1, all state updates; sample/sample_valid registered, visible next clk.
//  FSM:
//   IDLE: sample=midscale. start -> PLAY, note_idx=0, phase=0, dur_cnt=ROM[0].units*UNIT_TICKS.
//   PLAY: per sample_ce: phase += ROM[note_idx].inc (wraps mod 2^PHASE_W); sample from wave_sel;
//         dur_cnt-1; when dur_cnt reaches 0 on a ce -> GAP, gap_cnt=GAP_TICKS.
//   GAP: sample=midscale, phase=0. gap_cnt reaches 0 on a ce -> next note (PLAY);
//        after note NOTE_CNT-1: loop_en ? PLAY note 0 : IDLE.
//  Rest note: inc=0 -> sample forced midscale (not phase-derived) for its duration.
//  start while busy: ignored. stop: any state -> IDLE next clk, regardless of sample_ce;
//   sample=midscale, phase=0. start and stop same clk: stop wins.
//  start/stop act on the clk they arrive (need no sample_ce). First PLAY sample appears on the
//   ce after start.
//  Zero-duration ROM entry (units=0): treated as 1 tick; no underflow.
//  Widths: dur_cnt wide enough for max units*UNIT_TICKS (>=24 bits); unsigned arithmetic only.
//  sample_ce asserted two clks in a row (out of spec): each ce advances once; no lockup.
// STRUCTURE
//  Package tone_pkg: NOTE_CNT, note ROM (per entry: inc[PHASE_W-1:0], units[7:0]),
//   MIDSCALE constant, state enum {IDLE,PLAY,GAP}.
//   inc = round(f_hz * 2^24 / 4.8e6); A4 440 Hz = 1538, D5 587 Hz = 2052.
//  Sub-module tone_dds: phase accumulator + waveform select; ports clk, rst, ce, clr, inc,
//   wave_sel, sample. FSM, counters and ROM stay in tone_sequencer.
// TESTING
//  1 Reset mid-PLAY (rst pulse at note 3) -> same clk: sample=4096, busy=0, note_idx=0,
//    sample_valid=0.
//  2 start, saw, note inc=1538 -> after 2048 ces sample = (2048*1538)>>11 = 1538;
//    sample_valid pulses once per ce.
//  3 Short-param build (UNIT_TICKS=4, GAP_TICKS=2), note units=3 -> exactly 12 PLAY samples,
//    2 midscale GAP samples, then note_idx=1.
//  4 Last note ends, loop_en=0 -> IDLE, busy=0. loop_en=1 -> note_idx=0, PLAY, no extra gap.
//  5 start+stop same clk in IDLE -> stays IDLE. stop mid-GAP -> IDLE next clk, no ce needed.
//  6 wave_sel=1, phase MSB=1 -> sample=8191; MSB=0 -> 0. Rest entry -> 4096 for its duration.

Source files
------------

// File: rtl/tone_pkg.sv
// tone_pkg: shared widths, sample constants, FSM states and the melody ROM.
package tone_pkg;

  localparam int unsigned SAMPLE_W       = 13;
  localparam int unsigned PHASE_W        = 24;
  localparam int unsigned NOTE_CNT       = 8;
  localparam int unsigned NOTE_IDX_W     = $clog2(NOTE_CNT);
  localparam int unsigned UNITS_W        = 8;
  localparam int unsigned UNIT_TICKS_DEF = 48000;
  localparam int unsigned GAP_TICKS_DEF  = 4800;

  localparam logic [SAMPLE_W-1:0] MIDSCALE  = SAMPLE_W'(2 ** (SAMPLE_W - 1));
  localparam logic [SAMPLE_W-1:0] FULLSCALE = '1;

  typedef enum logic [1:0] {
    IDLE,
    PLAY,
    GAP
  } state_t;

  // One melody entry: DDS increment (0 = rest) and duration in units.
  typedef struct packed {
    logic [PHASE_W-1:0] inc;
    logic [UNITS_W-1:0] units;
  } note_t;

  // inc = round(f_hz * 2^24 / 4.8 MHz)
  localparam note_t NOTE_ROM [NOTE_CNT] = '{
    '{inc: PHASE_W'(1538), units: UNITS_W'(3)},  // A4  440 Hz
    '{inc: PHASE_W'(2052), units: UNITS_W'(2)},  // D5  587 Hz
    '{inc: PHASE_W'(0),    units: UNITS_W'(1)},  // rest
    '{inc: PHASE_W'(2303), units: UNITS_W'(2)},  // E5  659 Hz
    '{inc: PHASE_W'(2586), units: UNITS_W'(0)},  // F#5 740 Hz, shortest possible note
    '{inc: PHASE_W'(3076), units: UNITS_W'(2)},  // A5  880 Hz
    '{inc: PHASE_W'(2740), units: UNITS_W'(1)},  // G5  784 Hz
    '{inc: PHASE_W'(4107), units: UNITS_W'(4)}   // D6 1175 Hz
  };

endpackage

// File: rtl/tone_sequencer_if.sv
// tone_sequencer_if: control strobes in, sample stream and status out.
interface tone_sequencer_if;
  import tone_pkg::*;

  logic                  i_sample_ce;
  logic                  i_start;
  logic                  i_stop;
  logic                  i_loop_en;
  logic                  i_wave_sel;
  logic [SAMPLE_W-1:0]   o_sample;
  logic                  o_sample_valid;
  logic                  o_busy;
  logic [NOTE_IDX_W-1:0] o_note_idx;

  modport master (
    output i_sample_ce, i_start, i_stop, i_loop_en, i_wave_sel,
    input  o_sample, o_sample_valid, o_busy, o_note_idx
  );

  modport slave (
    input  i_sample_ce, i_start, i_stop, i_loop_en, i_wave_sel,
    output o_sample, o_sample_valid, o_busy, o_note_idx
  );

endinterface

// File: rtl/tone_dds.sv
// tone_dds: phase accumulator with sawtooth/square shaping of the post-increment phase.
module tone_dds
  import tone_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                i_ce,
  input  logic                i_clr,
  input  logic [PHASE_W-1:0]  i_inc,
  input  logic                i_wave_sel,
  output logic [SAMPLE_W-1:0] o_sample_c
);

  logic [PHASE_W-1:0] r_phase;
  logic [PHASE_W-1:0] w_phase_nxt;

  assign w_phase_nxt = r_phase + i_inc;

  // Phase accumulator; clear has priority over advance.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_phase <= '0;
    end else if (i_clr) begin
      r_phase <= '0;
    end else if (i_ce) begin
      r_phase <= w_phase_nxt;
    end
  end

  // Shape the phase the accumulator is about to hold, so the sample and phase stay aligned.
  always_comb begin
    o_sample_c = SAMPLE_W'(w_phase_nxt >> (PHASE_W - SAMPLE_W));
    if (i_wave_sel) begin
      o_sample_c = w_phase_nxt[PHASE_W-1] ? FULLSCALE : '0;
    end
  end

endmodule

// File: rtl/tone_sequencer.sv
// tone_sequencer: walks the note ROM (PLAY/GAP), driving the DDS once per sample enable.
module tone_sequencer
  import tone_pkg::*;
#(
  parameter int unsigned UNIT_TICKS = UNIT_TICKS_DEF,
  parameter int unsigned GAP_TICKS  = GAP_TICKS_DEF
) (
  input logic             clk,
  input logic             rst,
  tone_sequencer_if.slave bus
);

  localparam int unsigned DUR_BITS = $clog2(((2 ** UNITS_W) - 1) * UNIT_TICKS + 1);
  localparam int unsigned DUR_W    = (DUR_BITS > 24) ? DUR_BITS : 24;
  localparam int unsigned GAP_BITS = $clog2(GAP_TICKS + 1);
  localparam int unsigned GAP_W    = (GAP_BITS > 1) ? GAP_BITS : 1;

  // Note length in enables; a zero-unit entry still plays for one enable.
  function automatic logic [DUR_W-1:0] note_ticks(input logic [UNITS_W-1:0] units);
    logic [DUR_W-1:0] ticks;
    ticks = DUR_W'(units) * DUR_W'(UNIT_TICKS);
    if (ticks == '0) begin
      ticks = DUR_W'(1);
    end
    return ticks;
  endfunction

  state_t                r_state;
  state_t                w_state_nxt;
  logic [NOTE_IDX_W-1:0] r_note_idx;
  logic [NOTE_IDX_W-1:0] w_note_nxt;
  logic [NOTE_IDX_W-1:0] w_adv_idx;
  logic [DUR_W-1:0]      r_dur_cnt;
  logic [DUR_W-1:0]      w_dur_nxt;
  logic [GAP_W-1:0]      r_gap_cnt;
  logic [GAP_W-1:0]      w_gap_nxt;
  logic [SAMPLE_W-1:0]   r_sample;
  logic [SAMPLE_W-1:0]   w_sample_nxt;
  logic [SAMPLE_W-1:0]   w_dds_sample;
  logic [PHASE_W-1:0]    w_inc;
  logic                  r_sample_valid;
  logic                  r_busy;
  logic                  w_last_note;
  logic                  w_dds_ce;
  logic                  w_dds_clr;

  assign w_inc       = NOTE_ROM[r_note_idx].inc;
  assign w_last_note = (r_note_idx == NOTE_IDX_W'(NOTE_CNT - 1));
  assign w_adv_idx   = w_last_note ? '0 : r_note_idx + NOTE_IDX_W'(1);

  tone_dds u_dds (
    .clk        (clk),
    .rst        (rst),
    .i_ce       (w_dds_ce),
    .i_clr      (w_dds_clr),
    .i_inc      (w_inc),
    .i_wave_sel (bus.i_wave_sel),
    .o_sample_c (w_dds_sample)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state, counters and next sample; stop overrides everything, start/stop need no enable.
  always_comb begin
    w_state_nxt  = r_state;
    w_note_nxt   = r_note_idx;
    w_dur_nxt    = r_dur_cnt;
    w_gap_nxt    = r_gap_cnt;
    w_sample_nxt = r_sample;
    w_dds_ce     = 1'b0;
    w_dds_clr    = 1'b0;
    if (bus.i_stop) begin
      w_state_nxt  = IDLE;
      w_note_nxt   = '0;
      w_dur_nxt    = '0;
      w_gap_nxt    = '0;
      w_sample_nxt = MIDSCALE;
      w_dds_clr    = 1'b1;
    end else begin
      case (r_state)
        IDLE: begin
          w_dds_clr = 1'b1;
          if (bus.i_sample_ce) begin
            w_sample_nxt = MIDSCALE;
          end
          if (bus.i_start) begin
            w_state_nxt = PLAY;
            w_note_nxt  = '0;
            w_dur_nxt   = note_ticks(NOTE_ROM[0].units);
          end
        end
        PLAY: begin
          if (bus.i_sample_ce) begin
            w_dds_ce     = 1'b1;
            w_sample_nxt = (w_inc == '0) ? MIDSCALE : w_dds_sample;
            if (r_dur_cnt <= DUR_W'(1)) begin
              w_state_nxt = GAP;
              w_dur_nxt   = '0;
              w_gap_nxt   = GAP_W'(GAP_TICKS);
            end else begin
              w_dur_nxt = r_dur_cnt - DUR_W'(1);
            end
          end
        end
        GAP: begin
          w_dds_clr = 1'b1;
          if (bus.i_sample_ce) begin
            w_sample_nxt = MIDSCALE;
            if (r_gap_cnt <= GAP_W'(1)) begin
              w_gap_nxt = '0;
              if (w_last_note && !bus.i_loop_en) begin
                w_state_nxt = IDLE;
                w_note_nxt  = '0;
              end else begin
                w_state_nxt = PLAY;
                w_note_nxt  = w_adv_idx;
                w_dur_nxt   = note_ticks(NOTE_ROM[w_adv_idx].units);
              end
            end else begin
              w_gap_nxt = r_gap_cnt - GAP_W'(1);
            end
          end
        end
        default: begin
          w_state_nxt = IDLE;
        end
      endcase
    end
  end

  // Counters and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_note_idx     <= '0;
      r_dur_cnt      <= '0;
      r_gap_cnt      <= '0;
      r_sample       <= MIDSCALE;
      r_sample_valid <= 1'b0;
      r_busy         <= 1'b0;
    end else begin
      r_note_idx     <= w_note_nxt;
      r_dur_cnt      <= w_dur_nxt;
      r_gap_cnt      <= w_gap_nxt;
      r_sample       <= w_sample_nxt;
      r_sample_valid <= bus.i_sample_ce;
      r_busy         <= (w_state_nxt != IDLE);
    end
  end

  assign bus.o_sample       = r_sample;
  assign bus.o_sample_valid = r_sample_valid;
  assign bus.o_busy         = r_busy;
  assign bus.o_note_idx     = r_note_idx;

endmodule

// File: tb/tb_tone_sequencer.sv
// tb_tone_sequencer: directed checks on a short-duration build and a long-note build.
module tb_tone_sequencer;
  import tone_pkg::*;

  logic        clk;
  logic        rst;
  int unsigned n_checks;
  int unsigned n_pass;

  tone_sequencer_if s_if ();
  tone_sequencer_if l_if ();

  tone_sequencer #(.UNIT_TICKS(4), .GAP_TICKS(2)) dut_s (
    .clk (clk),
    .rst (rst),
    .bus (s_if.slave)
  );

  tone_sequencer #(.UNIT_TICKS(4096), .GAP_TICKS(2)) dut_l (
    .clk (clk),
    .rst (rst),
    .bus (l_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One enable on the short build followed by four idle clocks; counts valid pulses.
  task automatic s_ce(output logic [SAMPLE_W-1:0] smp, output logic [NOTE_IDX_W-1:0] idx,
                      output logic bsy, output int nv);
    nv = 0;
    s_if.i_sample_ce = 1'b1;
    @(negedge clk);
    s_if.i_sample_ce = 1'b0;
    smp = s_if.o_sample;
    idx = s_if.o_note_idx;
    bsy = s_if.o_busy;
    if (s_if.o_sample_valid === 1'b1) nv++;
    repeat (4) begin
      @(negedge clk);
      if (s_if.o_sample_valid === 1'b1) nv++;
    end
  endtask

  // One enable on the long build followed by 'idle' quiet clocks.
  task automatic l_ce(input int idle, output logic [SAMPLE_W-1:0] smp, output int nv);
    nv = 0;
    l_if.i_sample_ce = 1'b1;
    @(negedge clk);
    l_if.i_sample_ce = 1'b0;
    smp = l_if.o_sample;
    if (l_if.o_sample_valid === 1'b1) nv++;
    repeat (idle) begin
      @(negedge clk);
      if (l_if.o_sample_valid === 1'b1) nv++;
    end
  endtask

  task automatic s_pulse(input logic start, input logic stop);
    s_if.i_start = start;
    s_if.i_stop  = stop;
    @(negedge clk);
    s_if.i_start = 1'b0;
    s_if.i_stop  = 1'b0;
  endtask

  task automatic l_pulse(input logic start, input logic stop);
    l_if.i_start = start;
    l_if.i_stop  = stop;
    @(negedge clk);
    l_if.i_start = 1'b0;
    l_if.i_stop  = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_checks++;
    if (s_if.o_sample !== 13'd4096) $display("FAIL reset_sample: got %0d want 4096", s_if.o_sample);
    else n_pass++;
    n_checks++;
    if (s_if.o_busy !== 1'b0 || s_if.o_sample_valid !== 1'b0)
      $display("FAIL reset_flags: busy %0b valid %0b want 0 0", s_if.o_busy, s_if.o_sample_valid);
    else n_pass++;
    n_checks++;
    if (s_if.o_note_idx !== 3'd0) $display("FAIL reset_idx: got %0d want 0", s_if.o_note_idx);
    else n_pass++;
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_saw();
    logic [SAMPLE_W-1:0] smp;
    int nv;
    int total_nv;
    total_nv = 0;
    l_if.i_wave_sel = 1'b0;
    l_pulse(1'b1, 1'b0);
    n_checks++;
    if (l_if.o_busy !== 1'b1 || l_if.o_sample !== 13'd4096)
      $display("FAIL saw_start: busy %0b sample %0d want 1 4096", l_if.o_busy, l_if.o_sample);
    else n_pass++;
    for (int k = 1; k <= 2048; k++) begin
      l_ce(4, smp, nv);
      total_nv += nv;
      if (k == 1) begin
        n_checks++;
        if (smp !== 13'd0) $display("FAIL saw_first: got %0d want 0", smp);
        else n_pass++;
      end
      if (k == 1000) begin
        n_checks++;
        if (smp !== 13'd750) $display("FAIL saw_1000: got %0d want 750", smp);
        else n_pass++;
      end
    end
    n_checks++;
    if (smp !== 13'd1538) $display("FAIL saw_2048: got %0d want 1538", smp);
    else n_pass++;
    n_checks++;
    if (total_nv != 2048) $display("FAIL saw_valid_count: got %0d want 2048", total_nv);
    else n_pass++;
    l_pulse(1'b0, 1'b1);
  endtask

  task automatic test_back_to_back();
    logic [SAMPLE_W-1:0] smp;
    int nv;
    int total_nv;
    total_nv = 0;
    l_pulse(1'b1, 1'b0);
    l_ce(0, smp, nv);
    total_nv += nv;
    l_ce(0, smp, nv);
    total_nv += nv;
    n_checks++;
    if (smp !== 13'd1 || total_nv != 2)
      $display("FAIL b2b_two_ce: sample %0d valids %0d want 1 2", smp, total_nv);
    else n_pass++;
    l_ce(4, smp, nv);
    n_checks++;
    if (smp !== 13'd2) $display("FAIL b2b_third_ce: got %0d want 2", smp);
    else n_pass++;
    l_pulse(1'b0, 1'b1);
  endtask

  task automatic test_square();
    logic [SAMPLE_W-1:0] smp;
    int nv;
    l_if.i_wave_sel = 1'b1;
    l_pulse(1'b1, 1'b0);
    for (int k = 1; k <= 5454; k++) begin
      l_ce(0, smp, nv);
    end
    n_checks++;
    if (smp !== 13'd0) $display("FAIL square_low: got %0d want 0", smp);
    else n_pass++;
    l_ce(2, smp, nv);
    n_checks++;
    if (smp !== 13'd8191) $display("FAIL square_high: got %0d want 8191", smp);
    else n_pass++;
    l_pulse(1'b0, 1'b1);
    l_if.i_wave_sel = 1'b0;
  endtask

  task automatic test_note_timing();
    logic [SAMPLE_W-1:0] smp;
    logic [SAMPLE_W-1:0] exp_smp;
    logic [NOTE_IDX_W-1:0] idx;
    logic bsy;
    int nv;
    s_pulse(1'b1, 1'b0);
    for (int k = 1; k <= 12; k++) begin
      s_ce(smp, idx, bsy, nv);
      exp_smp = SAMPLE_W'((k * 1538) >> 11);
      n_checks++;
      if (smp !== exp_smp || bsy !== 1'b1 || nv != 1)
        $display("FAIL play_%0d: sample %0d busy %0b valids %0d want %0d 1 1", k, smp, bsy, nv, exp_smp);
      else n_pass++;
    end
    s_ce(smp, idx, bsy, nv);
    n_checks++;
    if (smp !== 13'd4096 || idx !== 3'd0 || bsy !== 1'b1)
      $display("FAIL gap_1: sample %0d idx %0d busy %0b want 4096 0 1", smp, idx, bsy);
    else n_pass++;
    s_ce(smp, idx, bsy, nv);
    n_checks++;
    if (smp !== 13'd4096 || idx !== 3'd1)
      $display("FAIL gap_2: sample %0d idx %0d want 4096 1", smp, idx);
    else n_pass++;
    s_ce(smp, idx, bsy, nv);
    n_checks++;
    if (smp !== 13'd1 || idx !== 3'd1)
      $display("FAIL note1_first: sample %0d idx %0d want 1 1", smp, idx);
    else n_pass++;
    s_pulse(1'b0, 1'b1);
  endtask

  task automatic test_melody_end();
    logic [SAMPLE_W-1:0] smp;
    logic [NOTE_IDX_W-1:0] idx;
    logic bsy;
    int nv;
    int ces;
    int idx2;
    int idx2_loud;
    int idx4;
    ces = 0;
    idx2 = 0;
    idx2_loud = 0;
    idx4 = 0;
    s_if.i_loop_en = 1'b0;
    s_pulse(1'b1, 1'b0);
    bsy = 1'b1;
    smp = '0;
    while (bsy === 1'b1 && ces < 200) begin
      s_ce(smp, idx, bsy, nv);
      ces++;
      if (idx === 3'd2) begin
        idx2++;
        if (smp !== 13'd4096) idx2_loud++;
      end
      if (idx === 3'd4) idx4++;
    end
    n_checks++;
    if (ces != 77) $display("FAIL melody_len: ces %0d want 77", ces);
    else n_pass++;
    n_checks++;
    if (idx2 != 6 || idx2_loud != 0)
      $display("FAIL rest_note: idx2 ces %0d loud %0d want 6 0", idx2, idx2_loud);
    else n_pass++;
    n_checks++;
    if (idx4 != 3) $display("FAIL zero_units: idx4 ces %0d want 3", idx4);
    else n_pass++;
    n_checks++;
    if (bsy !== 1'b0 || smp !== 13'd4096)
      $display("FAIL melody_idle: busy %0b sample %0d want 0 4096", bsy, smp);
    else n_pass++;
  endtask

  task automatic test_loop();
    logic [SAMPLE_W-1:0] smp;
    logic [NOTE_IDX_W-1:0] idx;
    logic bsy;
    int nv;
    s_if.i_loop_en = 1'b1;
    s_pulse(1'b1, 1'b0);
    for (int k = 1; k <= 76; k++) begin
      s_ce(smp, idx, bsy, nv);
    end
    n_checks++;
    if (idx !== 3'd7 || bsy !== 1'b1) $display("FAIL loop_last_gap: idx %0d busy %0b want 7 1", idx, bsy);
    else n_pass++;
    s_ce(smp, idx, bsy, nv);
    n_checks++;
    if (idx !== 3'd0 || bsy !== 1'b1 || smp !== 13'd4096)
      $display("FAIL loop_wrap: idx %0d busy %0b sample %0d want 0 1 4096", idx, bsy, smp);
    else n_pass++;
    s_ce(smp, idx, bsy, nv);
    n_checks++;
    if (smp !== 13'd0 || idx !== 3'd0 || bsy !== 1'b1)
      $display("FAIL loop_no_gap: sample %0d idx %0d busy %0b want 0 0 1", smp, idx, bsy);
    else n_pass++;
    s_pulse(1'b0, 1'b1);
    s_if.i_loop_en = 1'b0;
  endtask

  task automatic test_stop();
    logic [SAMPLE_W-1:0] smp;
    logic [NOTE_IDX_W-1:0] idx;
    logic bsy;
    int nv;
    s_pulse(1'b1, 1'b1);
    n_checks++;
    if (s_if.o_busy !== 1'b0) $display("FAIL start_stop_same: busy %0b want 0", s_if.o_busy);
    else n_pass++;
    s_ce(smp, idx, bsy, nv);
    n_checks++;
    if (bsy !== 1'b0 || smp !== 13'd4096)
      $display("FAIL idle_ce: busy %0b sample %0d want 0 4096", bsy, smp);
    else n_pass++;
    s_pulse(1'b1, 1'b0);
    for (int k = 1; k <= 5; k++) s_ce(smp, idx, bsy, nv);
    s_pulse(1'b1, 1'b0);
    s_ce(smp, idx, bsy, nv);
    n_checks++;
    if (smp !== 13'd4 || idx !== 3'd0)
      $display("FAIL start_ignored: sample %0d idx %0d want 4 0", smp, idx);
    else n_pass++;
    for (int k = 7; k <= 13; k++) s_ce(smp, idx, bsy, nv);
    n_checks++;
    if (bsy !== 1'b1 || smp !== 13'd4096)
      $display("FAIL in_gap: busy %0b sample %0d want 1 4096", bsy, smp);
    else n_pass++;
    s_pulse(1'b0, 1'b1);
    n_checks++;
    if (s_if.o_busy !== 1'b0 || s_if.o_note_idx !== 3'd0)
      $display("FAIL stop_gap: busy %0b idx %0d want 0 0", s_if.o_busy, s_if.o_note_idx);
    else n_pass++;
    s_pulse(1'b1, 1'b0);
    for (int k = 1; k <= 5; k++) s_ce(smp, idx, bsy, nv);
    s_pulse(1'b0, 1'b1);
    n_checks++;
    if (s_if.o_sample !== 13'd4096 || s_if.o_busy !== 1'b0)
      $display("FAIL stop_play: sample %0d busy %0b want 4096 0", s_if.o_sample, s_if.o_busy);
    else n_pass++;
    s_pulse(1'b1, 1'b0);
    s_ce(smp, idx, bsy, nv);
    s_ce(smp, idx, bsy, nv);
    n_checks++;
    if (smp !== 13'd1) $display("FAIL phase_cleared: got %0d want 1", smp);
    else n_pass++;
    s_pulse(1'b0, 1'b1);
  endtask

  task automatic test_reset_midplay();
    logic [SAMPLE_W-1:0] smp;
    logic [NOTE_IDX_W-1:0] idx;
    logic bsy;
    int nv;
    int ces;
    ces = 0;
    s_pulse(1'b1, 1'b0);
    idx = '0;
    while (idx !== 3'd3 && ces < 100) begin
      s_ce(smp, idx, bsy, nv);
      ces++;
    end
    n_checks++;
    if (idx !== 3'd3) $display("FAIL reach_note3: idx %0d want 3", idx);
    else n_pass++;
    s_if.i_sample_ce = 1'b1;
    @(negedge clk);
    s_if.i_sample_ce = 1'b0;
    n_checks++;
    if (s_if.o_busy !== 1'b1 || s_if.o_sample_valid !== 1'b1 || s_if.o_sample !== 13'd1)
      $display("FAIL note3_play: busy %0b valid %0b sample %0d want 1 1 1",
               s_if.o_busy, s_if.o_sample_valid, s_if.o_sample);
    else n_pass++;
    #1 rst = 1'b1;
    #1;
    n_checks++;
    if (s_if.o_sample !== 13'd4096 || s_if.o_busy !== 1'b0 ||
        s_if.o_note_idx !== 3'd0 || s_if.o_sample_valid !== 1'b0)
      $display("FAIL async_reset: sample %0d busy %0b idx %0d valid %0b want 4096 0 0 0",
               s_if.o_sample, s_if.o_busy, s_if.o_note_idx, s_if.o_sample_valid);
    else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst      = 1'b1;
    s_if.i_sample_ce = 1'b0;
    s_if.i_start     = 1'b0;
    s_if.i_stop      = 1'b0;
    s_if.i_loop_en   = 1'b0;
    s_if.i_wave_sel  = 1'b0;
    l_if.i_sample_ce = 1'b0;
    l_if.i_start     = 1'b0;
    l_if.i_stop      = 1'b0;
    l_if.i_loop_en   = 1'b0;
    l_if.i_wave_sel  = 1'b0;
    test_reset();
    test_saw();
    test_back_to_back();
    test_square();
    test_note_timing();
    test_melody_end();
    test_loop();
    test_stop();
    test_reset_midplay();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
